// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32 pipeline: load-use interlock,
// multi-cycle multiply sequencing, taken-branch squash and memory-wait freeze.
module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_LAT     = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid_inst,
    input  logic [4:0]             id_ra_idx,
    input  logic [4:0]             id_rb_idx,
    input  logic                   id_uses_ra,
    input  logic                   id_uses_rb,
    input  logic [4:0]             id_dest_reg_idx,
    input  logic                   id_rd_mem,
    input  logic                   id_is_mul,
    input  logic                   ex_take_branch,
    input  logic                   mem_busy,
    output logic                   if_hold,
    output logic                   id_ex_hold,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic                   ex_mem_hold,
    output logic                   ex_mem_bubble,
    output logic                   mul_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MUL    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    state_t           state, state_d, prev, prev_d, eff;
    logic [CNT_W-1:0] mul_cnt, mul_cnt_d;
    logic             sh_valid, sh_valid_d;
    logic             sh_rd_mem, sh_rd_mem_d;
    logic [4:0]       sh_dest, sh_dest_d;
    logic             load_use;
    logic             issue;

    // Next-state, shadow update and hazard enables in priority order
    always_comb begin
        state_d       = state;
        prev_d        = prev;
        mul_cnt_d     = mul_cnt;
        sh_valid_d    = sh_valid;
        sh_rd_mem_d   = sh_rd_mem;
        sh_dest_d     = sh_dest;
        if_hold       = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        ex_mem_hold   = 1'b0;
        ex_mem_bubble = 1'b0;
        mul_busy      = 1'b0;
        issue         = 1'b0;

        // While frozen, behave as the state the freeze interrupted
        eff = (state == ST_FREEZE) ? prev : state;

        load_use = sh_valid && sh_rd_mem && (sh_dest != 5'd0) && id_valid_inst &&
                   ((id_uses_ra && (id_ra_idx == sh_dest)) ||
                    (id_uses_rb && (id_rb_idx == sh_dest)));

        if (mem_busy) begin
            if_hold     = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            state_d     = ST_FREEZE;
            prev_d      = eff;
        end else begin
            state_d = eff;
            if (eff == ST_MUL) begin
                if_hold       = 1'b1;
                id_ex_hold    = 1'b1;
                ex_mem_bubble = 1'b1;
                if (mul_cnt <= CNT_W'(1)) begin
                    mul_cnt_d = '0;
                    state_d   = ST_RUN;
                end else begin
                    mul_cnt_d = mul_cnt - CNT_W'(1);
                end
            end else if (ex_take_branch) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                sh_valid_d   = 1'b0;
            end else if (load_use) begin
                if_hold      = 1'b1;
                id_ex_bubble = 1'b1;
                sh_valid_d   = 1'b0;
            end else begin
                issue      = id_valid_inst;
                sh_valid_d = issue;
                if (issue) begin
                    sh_dest_d   = id_dest_reg_idx;
                    sh_rd_mem_d = id_rd_mem;
                end
                if (issue && id_is_mul && (MUL_LAT > 1)) begin
                    state_d   = ST_MUL;
                    mul_cnt_d = CNT_W'(MUL_LAT - 1);
                end
            end
        end

        mul_busy = (eff == ST_MUL);

        if (!rst) begin
            if_hold       = 1'b0;
            id_ex_hold    = 1'b0;
            id_ex_bubble  = 1'b0;
            if_id_flush   = 1'b0;
            ex_mem_hold   = 1'b0;
            ex_mem_bubble = 1'b0;
            mul_busy      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            prev        <= ST_RUN;
            mul_cnt     <= '0;
            sh_valid    <= 1'b0;
            sh_rd_mem   <= 1'b0;
            sh_dest     <= '0;
            stall_count <= '0;
        end else begin
            state     <= state_d;
            prev      <= prev_d;
            mul_cnt   <= mul_cnt_d;
            sh_valid  <= sh_valid_d;
            sh_rd_mem <= sh_rd_mem_d;
            sh_dest   <= sh_dest_d;
            // Saturating count of held-upstream cycles
            if (if_hold && (stall_count != '1))
                stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances (MUL_LAT 3/4,
// 4-bit counter) share stimulus; each step checks hand-computed enables.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_inst;
    logic [4:0] id_ra_idx, id_rb_idx, id_dest_reg_idx;
    logic       id_uses_ra, id_uses_rb, id_rd_mem, id_is_mul;
    logic       ex_take_branch, mem_busy;

    logic [6:0]  vec_a, vec_b, vec_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int n_vec = 0;
    int n_err = 0;

    // {if_hold, id_ex_hold, id_ex_bubble, if_id_flush, ex_mem_hold, ex_mem_bubble, mul_busy}
    localparam logic [6:0] V_IDLE = 7'b0000000;
    localparam logic [6:0] V_LU   = 7'b1010000;
    localparam logic [6:0] V_BR   = 7'b0011000;
    localparam logic [6:0] V_MUL  = 7'b1100011;
    localparam logic [6:0] V_FRZ  = 7'b1100100;
    localparam logic [6:0] V_FRZM = 7'b1100101;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_LAT(3), .STALL_CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid_inst(id_valid_inst),
        .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
        .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_dest_reg_idx(id_dest_reg_idx), .id_rd_mem(id_rd_mem), .id_is_mul(id_is_mul),
        .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
        .if_hold(vec_a[6]), .id_ex_hold(vec_a[5]), .id_ex_bubble(vec_a[4]),
        .if_id_flush(vec_a[3]), .ex_mem_hold(vec_a[2]), .ex_mem_bubble(vec_a[1]),
        .mul_busy(vec_a[0]), .stall_count(cnt_a)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(4), .STALL_CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_valid_inst(id_valid_inst),
        .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
        .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_dest_reg_idx(id_dest_reg_idx), .id_rd_mem(id_rd_mem), .id_is_mul(id_is_mul),
        .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
        .if_hold(vec_b[6]), .id_ex_hold(vec_b[5]), .id_ex_bubble(vec_b[4]),
        .if_id_flush(vec_b[3]), .ex_mem_hold(vec_b[2]), .ex_mem_bubble(vec_b[1]),
        .mul_busy(vec_b[0]), .stall_count(cnt_b)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(3), .STALL_CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_valid_inst(id_valid_inst),
        .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
        .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_dest_reg_idx(id_dest_reg_idx), .id_rd_mem(id_rd_mem), .id_is_mul(id_is_mul),
        .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
        .if_hold(vec_c[6]), .id_ex_hold(vec_c[5]), .id_ex_bubble(vec_c[4]),
        .if_id_flush(vec_c[3]), .ex_mem_hold(vec_c[2]), .ex_mem_bubble(vec_c[1]),
        .mul_busy(vec_c[0]), .stall_count(cnt_c)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid_inst = 1'b0; id_ra_idx = '0; id_rb_idx = '0; id_dest_reg_idx = '0;
        id_uses_ra = 1'b0; id_uses_rb = 1'b0; id_rd_mem = 1'b0; id_is_mul = 1'b0;
        ex_take_branch = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic inst(input logic [4:0] dest, input logic ld, input logic mul,
                        input logic ua, input logic [4:0] ra, input logic ub, input logic [4:0] rb);
        id_valid_inst = 1'b1; id_dest_reg_idx = dest; id_rd_mem = ld; id_is_mul = mul;
        id_uses_ra = ua; id_ra_idx = ra; id_uses_rb = ub; id_rb_idx = rb;
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b0;
        mem_busy = 1'b1;
        ex_take_branch = 1'b1;
        #3;
        chk("reset_out_a", 16'(vec_a), 16'(V_IDLE));
        chk("reset_out_c", 16'(vec_c), 16'(V_IDLE));
        chk("reset_cnt_a", cnt_a, 16'd0);
        tick();
        clr();
        rst = 1'b1;
        #1;

        // load-use: lw x5 then reader of x5
        inst(5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("lw_issue", 16'(vec_a), 16'(V_IDLE));
        tick();
        inst(5'd6, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1 chk("lu_stall", 16'(vec_a), 16'(V_LU));
        tick();
        #1 chk("lu_release", 16'(vec_a), 16'(V_IDLE));
        chk("lu_cnt", cnt_a, 16'd1);
        tick();

        // load to x0 then x0 reader; non-load x5 then rb reader of x5
        inst(5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        inst(5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0);
        #1 chk("lw_x0_nostall", 16'(vec_a), 16'(V_IDLE));
        tick();
        inst(5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        inst(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
        #1 chk("alu_x5_nostall", 16'(vec_a), 16'(V_IDLE));
        tick();
        // lw x7 then rb reader of x7
        inst(5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        inst(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
        #1 chk("lu_rb_stall", 16'(vec_a), 16'(V_LU));
        tick();
        chk("lu_rb_cnt", cnt_a, 16'd2);

        // MUL with MUL_LAT=3, branch pulse during first held cycle ignored
        inst(5'd8, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("mul_issue", 16'(vec_a), 16'(V_IDLE));
        tick();
        inst(5'd10, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        ex_take_branch = 1'b1;
        #1 chk("mul_c1_branch_ignored", 16'(vec_a), 16'(V_MUL));
        tick();
        ex_take_branch = 1'b0;
        #1 chk("mul_c2", 16'(vec_a), 16'(V_MUL));
        tick();
        #1 chk("mul_done", 16'(vec_a), 16'(V_IDLE));
        chk("mul_cnt", cnt_a, 16'd4);
        tick();

        // branch in the same cycle as a load-use match
        inst(5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        inst(5'd11, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0);
        ex_take_branch = 1'b1;
        #1 chk("branch_over_lu", 16'(vec_a), 16'(V_BR));
        tick();
        ex_take_branch = 1'b0;
        #1 chk("branch_no_extra_stall", 16'(vec_a), 16'(V_IDLE));
        chk("branch_cnt", cnt_a, 16'd4);
        tick();

        // freeze of 2 cycles mid-MUL on the MUL_LAT=4 instance
        clr();
        rst_pulse();
        inst(5'd8, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        inst(5'd10, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("fm_mul_c1", 16'(vec_b), 16'(V_MUL));
        tick();
        mem_busy = 1'b1;
        #1 chk("fm_frz1", 16'(vec_b), 16'(V_FRZM));
        tick();
        #1 chk("fm_frz2", 16'(vec_b), 16'(V_FRZM));
        tick();
        mem_busy = 1'b0;
        #1 chk("fm_mul_c2", 16'(vec_b), 16'(V_MUL));
        tick();
        #1 chk("fm_mul_c3", 16'(vec_b), 16'(V_MUL));
        tick();
        #1 chk("fm_done", 16'(vec_b), 16'(V_IDLE));
        chk("fm_cnt", cnt_b, 16'd5);
        tick();

        // asynchronous reset mid-MUL
        clr();
        rst_pulse();
        inst(5'd8, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        clr();
        #1 chk("ar_mul_c1", 16'(vec_a), 16'(V_MUL));
        tick();
        chk("ar_pre_cnt", cnt_a, 16'd1);
        mem_busy = 1'b1;
        #2 rst = 1'b0;
        #1 chk("ar_out_a", 16'(vec_a), 16'(V_IDLE));
        chk("ar_out_b", 16'(vec_b), 16'(V_IDLE));
        chk("ar_cnt_a", cnt_a, 16'd0);
        chk("ar_cnt_b", cnt_b, 16'd0);

        // 20 freeze cycles: 4-bit counter saturates at 15
        rst = 1'b1;
        #1 chk("sat_frz_out", 16'(vec_c), 16'(V_FRZ));
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt_c", 16'(cnt_c), 16'd15);
        chk("sat_cnt_a", cnt_a, 16'd20);
        mem_busy = 1'b0;
        #1 chk("sat_release", 16'(vec_c), 16'(V_IDLE));
        tick();
        chk("sat_hold_c", 16'(cnt_c), 16'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage RV32 pipeline. It tracks the instruction held in ID/EX and a multi-cycle MUL/MULHU occupying EX, and drives the hold, bubble and flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers. It owns the load-use interlock, the multi-cycle multiply sequencing, taken-branch squashing and data-memory wait freezes. The ID-stage forwarding network stays in ID and is not duplicated here.

## Interface
- MUL_LAT, 3: total cycles a MUL/MULHU spends in EX; legal range 1..15.
- STALL_CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- id_valid_inst  in  1  the instruction in IF/ID is valid.
- id_ra_idx, id_rb_idx  in  5  source register indices of the ID instruction.
- id_uses_ra, id_uses_rb  in  1  the ID instruction actually reads ra/rb.
- id_dest_reg_idx  in  5  destination register of the ID instruction; 0 means no write.
- id_rd_mem  in  1  the ID instruction is a load.
- id_is_mul  in  1  the ID instruction is MUL or MULHU.
- ex_take_branch  in  1  the branch or jump in EX resolved taken this cycle.
- mem_busy  in  1  data memory is not ready; the whole pipeline freezes.
- if_hold  out  1  PC and IF/ID hold their values.
- id_ex_hold  out  1  ID/EX holds its value.
- id_ex_bubble  out  1  ID/EX loads a NOP.
- if_id_flush  out  1  IF/ID loads a NOP.
- ex_mem_hold  out  1  EX/MEM holds its value.
- ex_mem_bubble  out  1  EX/MEM loads a NOP.
- mul_busy  out  1  a multiply is occupying EX.
- stall_count  out  STALL_CNT_W  cycles with if_hold=1 since reset; saturates at all-ones.

## Operation
- Shadow registers sh_valid, sh_dest (5 bits) and sh_rd_mem describe the ID/EX contents.
- An ID instruction is "issued" in a cycle with id_valid_inst=1 and if_hold=0 and id_ex_bubble=0 and if_id_flush=0.
  - On issue, the shadow registers load the ID instruction's fields.
  - When id_ex_bubble or if_id_flush is asserted, sh_valid is cleared.
  - When id_ex_hold is asserted, the shadow registers keep their values.
- The FSM has three states: RUN, MUL, FREEZE.
  - RUN: normal operation.
  - MUL: mul_cnt (4 bits) counts down.
  - FREEZE: entered whenever mem_busy=1. The prior state is remembered so the FSM returns to it when mem_busy falls.
- Priority of conditions, highest first:
  1. Freeze. mem_busy=1 → if_hold=id_ex_hold=ex_mem_hold=1 and all bubble/flush outputs 0. No shadow, mul_cnt or FSM update other than the freeze bookkeeping; stall_count still increments.
  2. MUL. In state MUL → if_hold=id_ex_hold=1 and ex_mem_bubble=1. ex_take_branch is ignored, because EX holds a MUL. mul_cnt decrements each cycle; when mul_cnt reaches 0 the FSM returns to RUN.
  3. Branch. In RUN with ex_take_branch=1 → if_id_flush=1 and id_ex_bubble=1. This overrides the load-use stall, and the ID instruction is not issued.
  4. Load-use. In RUN with sh_valid & sh_rd_mem & sh_dest≠0, and (id_uses_ra & id_ra_idx==sh_dest or id_uses_rb & id_rb_idx==sh_dest), and id_valid_inst → if_hold=1 and id_ex_bubble=1 for one cycle.
  5. Otherwise all outputs are 0.
- MUL issue: issuing an instruction with id_is_mul=1 in RUN when MUL_LAT>1 moves the FSM to MUL on the next edge with mul_cnt=MUL_LAT-1. When MUL_LAT=1 the FSM stays in RUN.
- mul_busy = (state==MUL), or state==FREEZE with the remembered state MUL.
- Reset (rst=0, asynchronous, any time including mid-MUL):
  - state=RUN, mul_cnt=0, sh_valid=0, sh_dest=0, sh_rd_mem=0, stall_count=0.
  - All outputs are 0 while reset is asserted.

## Timing
- All hold, bubble and flush outputs are combinational from the current state and inputs, and are valid in the same cycle. State updates only on the rising edge of clk.
- Load-use stall costs exactly 1 cycle.
- A MUL issued at edge N holds EX for MUL_LAT cycles. Upstream is held for cycles N+1 .. N+MUL_LAT-1. The MUL result enters EX/MEM at edge N+MUL_LAT.
- Taken branch: one cycle of flush, squashing two slots (IF/ID and ID/EX).
- A freeze during MUL extends the MUL by exactly the number of freeze cycles.
- stall_count counts cycles with if_hold=1, including freeze cycles. It holds at 2^STALL_CNT_W-1 with no wrap.

## Test plan
- Load-use: issue `lw x5`, then next cycle an ID instruction reading x5 → if_hold=1, id_ex_bubble=1 for 1 cycle, then issue proceeds; stall_count=1.
- Load to x0 followed by a reader of x0 → no stall. A non-load writing x5 followed by a reader of x5 → no stall.
- MUL with MUL_LAT=3: issue at edge N → mul_busy=1 and ex_mem_bubble=1 in cycles N+1 and N+2, FSM back in RUN at edge N+3; a branch pulse during cycle N+1 produces no flush.
- ex_take_branch=1 in the same cycle as a load-use match → if_id_flush=1, id_ex_bubble=1, sh_valid=0 next cycle, no extra stall cycle.
- mem_busy=1 for 2 cycles mid-MUL (MUL_LAT=4) → all holds=1 during the freeze, the MUL completes 2 cycles later than unfrozen, stall_count counts the freeze cycles.
- rst=0 asserted asynchronously mid-MUL → all outputs 0 immediately, mul_busy=0, stall_count=0.
- Counter saturation with STALL_CNT_W=4: 20 consecutive freeze cycles → stall_count stops at 15.
